// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and the write-request record used by the write-back scheduler
package rf_wb_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } rf_wr_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: sync FIFO of write requests that exposes every slot's valid bit and address
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  rf_wr_req_t                push_req,
    input  logic                      pop,
    output rf_wr_req_t                head,
    output logic                      full,
    output logic                      empty,
    output logic [PW:0]               count,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][AW-1:0]  ent_waddr
);
    rf_wr_req_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Storage carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head  = mem[rd_ptr];
    assign full  = count == (PW + 1)'(DEPTH);
    assign empty = count == '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off          = PW'(i) - rd_ptr;
        assign ent_valid[i] = {1'b0, off} < count;
        assign ent_waddr[i] = mem[i].waddr;
    end
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: merges core and aux write-back onto one RF port; RF_WB_STALL_EN adds starvation stall
module rf_wb_sched
    import rf_wb_pkg::*;
#(
    parameter int AUX_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           core_wr_en,
    input  logic [AW-1:0]                  core_waddr,
    input  logic [DW-1:0]                  core_wdata,
    output logic                           core_stall,
    input  logic                           aux_valid,
    output logic                           aux_ready,
    input  logic [AW-1:0]                  aux_waddr,
    input  logic [DW-1:0]                  aux_wdata,
    output logic                           rf_reg_wr,
    output logic [AW-1:0]                  rf_waddr,
    output logic [DW-1:0]                  rf_wdata,
    output logic [NREG-1:0]                busy_vec,
    output logic [$clog2(AUX_DEPTH):0]     aux_count
);
    rf_wr_req_t head;
    logic full, empty, push, pop, core_ok;
    logic [AUX_DEPTH-1:0] ent_valid;
    logic [AUX_DEPTH-1:0][AW-1:0] ent_waddr;

    assign aux_ready = !full;
    assign push      = aux_valid & !full & |aux_waddr;
    assign core_ok   = core_wr_en & |core_waddr;
    assign pop       = !empty & (core_stall | !core_ok);
    assign rf_reg_wr = pop | core_ok;
    assign rf_waddr  = pop ? head.waddr : core_waddr;
    assign rf_wdata  = pop ? head.wdata : core_wdata;

    rf_wb_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_req  ('{waddr: aux_waddr, wdata: aux_wdata}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (aux_count),
        .ent_valid (ent_valid),
        .ent_waddr (ent_waddr)
    );

    // Scoreboard: a register is busy while any queued aux write targets it.
    always_comb begin
        busy_vec = '0;
        for (int k = 0; k < AUX_DEPTH; k++) if (ent_valid[k]) busy_vec[ent_waddr[k]] = 1'b1;
        busy_vec[0] = 1'b0;
    end

`ifdef RF_WB_STALL_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    // Counts cycles the head has waited; the stall it triggers forces a pop, so it never exceeds the limit.
    always_ff @(posedge clk) begin
        starve_cnt <= (rst || pop || empty) ? '0 : starve_cnt + 1'b1;
    end

    assign core_stall = (starve_cnt >= SW'(STARVE_LIMIT)) & !empty;
`else
    assign core_stall = 1'b0;
`endif

    core_into_busy: assert property (@(posedge clk) disable iff (rst)
        !(core_ok && !core_stall && busy_vec[core_waddr]));
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: random and directed stimulus against a queue-based write-back model
module tb_rf_wb_sched;
    import rf_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef RF_WB_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic core_wr_en, aux_valid;
    logic [AW-1:0] core_waddr, aux_waddr;
    logic [DW-1:0] core_wdata, aux_wdata;
    logic core_stall, aux_ready, rf_reg_wr;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NREG-1:0] busy_vec;
    logic [$clog2(DEPTH):0] aux_count;

    int checks = 0;
    int failures = 0;
    rf_wr_req_t q[$];
    int waited = 0;

    always #5 clk = ~clk;

    rf_wb_sched #(.AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_wr_en (core_wr_en),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_waddr  (aux_waddr),
        .aux_wdata  (aux_wdata),
        .rf_reg_wr  (rf_reg_wr),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy_vec   (busy_vec),
        .aux_count  (aux_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        foreach (q[k]) b[q[k].waddr] = 1'b1;
        return b;
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge, drive next inputs after.
    task automatic step();
        logic stall, core_ok, pop, accept;
        @(negedge clk);
        stall   = STALL_EN && q.size() > 0 && waited >= LIMIT;
        core_ok = core_wr_en && core_waddr != 0;
        pop     = q.size() > 0 && (stall || !core_ok);
        accept  = aux_valid && q.size() < DEPTH && aux_waddr != 0;
        if (!rst) begin
            chk("core_stall", 64'(core_stall), 64'(stall));
            chk("aux_ready", 64'(aux_ready), 64'(q.size() < DEPTH));
            chk("aux_count", 64'(aux_count), 64'(q.size()));
            chk("busy_vec", 64'(busy_vec), 64'(model_busy()));
            chk("rf_reg_wr", 64'(rf_reg_wr), 64'(pop || core_ok));
            if (pop) begin
                chk("rf_waddr_aux", 64'(rf_waddr), 64'(q[0].waddr));
                chk("rf_wdata_aux", 64'(rf_wdata), 64'(q[0].wdata));
            end else if (core_ok) begin
                chk("rf_waddr_core", 64'(rf_waddr), 64'(core_waddr));
                chk("rf_wdata_core", 64'(rf_wdata), 64'(core_wdata));
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            waited = 0;
        end else begin
            waited = (pop || q.size() == 0) ? 0 : waited + 1;
            if (pop) void'(q.pop_front());
            if (accept) q.push_back('{waddr: aux_waddr, wdata: aux_wdata});
        end
        #1;
    endtask

    task automatic drive(input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        core_wr_en = cw; core_waddr = ca; core_wdata = cd;
        aux_valid = av; aux_waddr = aa; aux_wdata = ad;
        step();
    endtask

    function automatic logic [AW-1:0] free_reg();
        logic [NREG-1:0] b = model_busy();
        logic [AW-1:0] a;
        do a = AW'($urandom_range(0, NREG - 1)); while (b[a]);
        return a;
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("reset_count_const", 64'(aux_count), 64'd0);
        // Core-only write passes through the same cycle.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        // Two aux pushes under continuous core traffic, then drain on idle.
        drive(1, 3, 32'h1, 1, 7, 32'h11);
        drive(1, 4, 32'h2, 1, 9, 32'h22);
        drive(1, 6, 32'h3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Fill to four, hold a fifth request, then an x0 write once there is room.
        for (int i = 0; i < 6; i++) drive(1, 1, 32'(i), 1, AW'(10 + i), 32'(100 + i));
        drive(0, 0, 0, 1, 20, 32'h55);
        drive(1, 2, 32'h9, 1, 0, 32'h77);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
        // One queued entry with core writing every cycle: starvation path.
        drive(1, 2, 32'hA, 1, 12, 32'hC0);
        for (int i = 0; i < 11; i++) drive(1, AW'(13 + i), 32'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++) drive(1, 1, 32'(i), 1, AW'(20 + i), 32'(200 + i));
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_count_const", 64'(aux_count), 64'd0);
        chk("post_rst_busy_const", 64'(busy_vec), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 6, ($urandom_range(0, 15) == 0) ? AW'(0) : free_reg(),
                  $urandom, $urandom_range(0, 1) == 1, AW'($urandom_range(0, NREG - 1)), $urandom);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
